// File: rtl/cnn_pkg.sv
// Shared constants, class index type and argmax FSM states
// for the cnn output stage and its classification consumer.
package cnn_pkg;
  localparam int CHANNELS_OUT = 5;
  localparam int O_WIDTH      = 16;
  localparam int PIXELS_OUT   = 1860;
  localparam int CLASS_W      = $clog2(CHANNELS_OUT);

  typedef logic [CLASS_W-1:0] class_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;
endpackage

// File: rtl/cnn_channel_accumulator.sv
// One channel of global sum pooling: sign-extend, add, clear, snapshot.
// accept/last qualify the sample; snap holds the finished frame sum.
module cnn_channel_accumulator #(
  parameter int D_WIDTH   = 16,
  parameter int ACC_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept,
  input  logic                 last,
  input  logic [D_WIDTH-1:0]   sample,
  output logic [ACC_WIDTH-1:0] snap
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] snap_q, snap_d;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] sum;

  assign ext = {{(ACC_WIDTH-D_WIDTH){sample[D_WIDTH-1]}}, sample};
  assign sum = acc_q + ext;

  always_comb begin
    acc_d  = acc_q;
    snap_d = snap_q;
    if (accept) begin
      if (last) begin
        snap_d = sum;
        acc_d  = '0;
      end else begin
        acc_d  = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      snap_q <= '0;
    end else begin
      acc_q  <= acc_d;
      snap_q <= snap_d;
    end
  end

  assign snap = snap_q;
endmodule

// File: rtl/cnn_class_argmax.sv
// Global sum pooling of the cnn output stream and a sequential argmax
// over the per-frame channel sums; result_valid pulses with class_idx/score.
module cnn_class_argmax
  import cnn_pkg::*;
#(
  parameter int CHANNELS         = CHANNELS_OUT,
  parameter int D_WIDTH          = O_WIDTH,
  parameter int PIXELS_PER_FRAME = PIXELS_OUT,
  parameter int ACC_WIDTH        = 28,
  parameter int IDX_WIDTH        = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic [CHANNELS*D_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic [IDX_WIDTH-1:0]        class_idx,
  output logic [ACC_WIDTH-1:0]        class_score,
  output logic                        result_valid,
  output logic                        busy
);
  localparam int CNT_W = $clog2(PIXELS_PER_FRAME);

  if (ACC_WIDTH < D_WIDTH + $clog2(PIXELS_PER_FRAME)) begin : g_acc_chk
    $error("ACC_WIDTH too small for frame sum");
  end
  if (PIXELS_PER_FRAME <= CHANNELS + 1) begin : g_pix_chk
    $error("frame too short to cover the argmax scan");
  end

  logic                 accept;
  logic                 last_pix;
  logic [ACC_WIDTH-1:0] snap [CHANNELS];

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  state_e                      state_q, state_d;
  logic [IDX_WIDTH-1:0]        scan_c_q, scan_c_d;
  logic signed [ACC_WIDTH-1:0] best_q, best_d;
  logic [IDX_WIDTH-1:0]        best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]        class_idx_q, class_idx_d;
  logic [ACC_WIDTH-1:0]        class_score_q, class_score_d;
  logic                        rv_q, rv_d;

  assign accept   = clk_en & in_valid;
  assign last_pix = accept && (cnt_q == CNT_W'(PIXELS_PER_FRAME-1));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_acc
    cnn_channel_accumulator #(
      .D_WIDTH  (D_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .accept(accept),
      .last  (last_pix),
      .sample(in_data[g*D_WIDTH +: D_WIDTH]),
      .snap  (snap[g])
    );
  end

  always_comb begin
    cnt_d         = cnt_q;
    state_d       = state_q;
    scan_c_d      = scan_c_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    rv_d          = rv_q;
    if (accept) begin
      cnt_d = last_pix ? '0 : cnt_q + CNT_W'(1);
    end
    if (clk_en) begin
      rv_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (last_pix) begin
            state_d  = SCAN;
            scan_c_d = '0;
          end
        end
        SCAN: begin
          // c=0 is the entry step: snapshot is only readable one edge after frame end
          if (scan_c_q == '0) begin
            best_d     = snap[0];
            best_idx_d = '0;
            scan_c_d   = IDX_WIDTH'(1);
          end else begin
            if ($signed(snap[scan_c_q]) > best_q) begin
              best_d     = snap[scan_c_q];
              best_idx_d = scan_c_q;
            end
            if (scan_c_q == IDX_WIDTH'(CHANNELS-1)) begin
              state_d = DONE;
            end else begin
              scan_c_d = scan_c_q + IDX_WIDTH'(1);
            end
          end
        end
        DONE: begin
          class_idx_d   = best_idx_q;
          class_score_d = best_q;
          rv_d          = 1'b1;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      state_q       <= IDLE;
      scan_c_q      <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      rv_q          <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      scan_c_q      <= scan_c_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      rv_q          <= rv_d;
    end
  end

  assign class_idx    = class_idx_q;
  assign class_score  = class_score_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_cnn_class_argmax.sv
// Scoreboard bench for cnn_class_argmax: table frames,
// random gaps with clk_en freeze, and reset mid-frame.
module tb_cnn_class_argmax;
  localparam int PIX = 1860;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [79:0] in_data;
  logic        in_valid;
  logic [2:0]  class_idx;
  logic [27:0] class_score;
  logic        result_valid;
  logic        busy;

  cnn_class_argmax dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .result_valid(result_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][15:0] smp;
    int               idx;
    int               score;
  } vec_t;

  typedef struct {
    int     idx;
    int     score;
    longint en_e;
    longint raw_e;
    bit     raw_chk;
  } exp_t;

  vec_t   tab [5];
  exp_t   sb [$];
  exp_t   it;
  int     errors = 0;
  int     checks = 0;
  longint en_e = 0;
  longint raw_e = 0;
  logic   prev_rv = 1'b0;
  longint prev_en = 0;

  always @(posedge clk) begin
    raw_e++;
    if (clk_en) en_e++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4:0][15:0] pk(int c0, int c1, int c2, int c3, int c4);
    logic [4:0][15:0] r;
    r[0] = 16'(c0);
    r[1] = 16'(c1);
    r[2] = 16'(c2);
    r[3] = 16'(c3);
    r[4] = 16'(c4);
    return r;
  endfunction

  always @(negedge clk) begin
    if (result_valid) begin
      if (prev_rv && en_e != prev_en) begin
        checks++;
        errors++;
        $display("FAIL pulse_width: result_valid high for %0d enabled cycles, required 1", 2);
      end else if (!prev_rv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got idx %0d score %0d, required no result",
                   class_idx, $signed(class_score));
        end else begin
          it = sb.pop_front();
          chk("class_idx", longint'(class_idx), it.idx);
          chk("class_score", longint'($signed(class_score)), it.score);
          chk("latency_en", en_e - it.en_e, 6);
          if (it.raw_chk) chk("latency_raw", raw_e - it.raw_e, 16);
        end
      end
    end
    prev_rv = result_valid;
    prev_en = en_e;
  end

  task automatic push_exp(input int idx, input int score, input bit rc);
    exp_t e;
    e.idx     = idx;
    e.score   = score;
    e.en_e    = en_e;
    e.raw_e   = raw_e;
    e.raw_chk = rc;
    sb.push_back(e);
  endtask

  task automatic drive_frame(input logic [4:0][15:0] s);
    for (int p = 0; p < PIX; p++) begin
      in_data  = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    longint sums [5];
    int     v;
    int     bi;
    longint bs;
    for (int c = 0; c < 5; c++) sums[c] = 0;
    for (int p = 0; p < PIX; p++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) begin
          clk_en   = 1'b0;
          in_valid = 1'b1;
          in_data  = {$urandom, $urandom, $urandom};
        end else begin
          clk_en   = 1'b1;
          in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      clk_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
        v = int'($urandom_range(0, 400)) - 200;
        sums[c] += v;
        in_data[c*16 +: 16] = 16'(v);
      end
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    bi = 0;
    bs = sums[0];
    for (int c = 1; c < 5; c++) begin
      if (sums[c] > bs) begin
        bs = sums[c];
        bi = c;
      end
    end
    push_exp(bi, int'(bs), 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_frozen", longint'(busy), 1);
    chk("rv_frozen_low", longint'(result_valid), 0);
    clk_en = 1'b1;
  endtask

  initial begin
    tab[0] = '{pk(0, 0, 3, 0, 0),       2, 5580};
    tab[1] = '{pk(-1, -2, -2, -2, -2),  0, -1860};
    tab[2] = '{pk(0, 7, 0, 7, 0),       1, 13020};
    tab[3] = '{pk(0, 0, 0, 0, 32767),   4, 60946620};
    tab[4] = '{pk(-4, 1, -3, 1, 0),     1, 1860};

    rst_n    = 1'b0;
    clk_en   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idx", longint'(class_idx), 0);
    chk("rst_score", longint'(class_score), 0);
    chk("rst_rv", longint'(result_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 5; r++) begin
      drive_frame(tab[r].smp);
      in_valid = 1'b1;
      push_exp(tab[r].idx, tab[r].score, 1'b0);
      chk("busy_scan", longint'(busy), 1);
    end
    in_valid = 1'b0;
    drain();

    rand_frame();
    drain();

    for (int p = 0; p < 900; p++) begin
      in_data  = pk(50, 0, 0, 0, 0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst2_idx", longint'(class_idx), 0);
    chk("rst2_score", longint'(class_score), 0);
    chk("rst2_busy", longint'(busy), 0);
    drive_frame(pk(0, 0, 0, 1, 0));
    push_exp(3, 1860, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
